cache_access_controller: RTL
============================

Name: cache_access_controller

Overview:
- Sequencing controller for the 4-line fully-associative cache and its backing synchronous RAM (single port, registered read).
- Owns the line state: valid, dirty, 2-bit LRU age, 7-bit tag and 5-bit block per line.
- Accepts one read or write request at a time over a Req/Ready handshake and performs lookup, dirty write-back, fill and LRU update.
- Returns BlockOut, hit and a Done pulse to the board-level top.

Parameters:
- TAG_W, 7, address/tag width; the full address is the tag.
- DATA_W, 5, block width.
- LINES, 4, line count; fixed at 4 because LRU ages are 2 bits.
- MEM_LAT, 1, RAM read latency in clocks, from address presented to q valid.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high.
- Req  in  1  request valid.
- Write  in  1  1 = write, 0 = read; sampled with Req.
- Address  in  TAG_W  request address.
- BlockIn  in  DATA_W  write data.
- Ready  out  1  high only in IDLE; a request is accepted on an edge with Req && Ready.
- Done  out  1  one-cycle completion pulse.
- BlockOut  out  DATA_W  read data, or written data for a write; held until the next Done.
- hit  out  1  1 if the lookup matched a valid line; held until the next Done.
- C_Addr_M  out  TAG_W  RAM address.
- C_Block_M  out  DATA_W  RAM write data.
- C_Write_M  out  1  RAM write enable.
- M_Block_C  in  DATA_W  RAM read data.

Behaviour:
- Reset (one clock is enough):
  - state = IDLE; Ready = 1.
  - Done, hit, BlockOut, C_Write_M, C_Addr_M, C_Block_M all = 0.
  - Every line: valid = 0, dirty = 0, tag = 0, data = 0; lru[i] = i.
- Reset mid-operation: the request is abandoned with no write-back and no Done. Any C_Write_M pulse in flight drops on the next edge.
- LRU invariant: the ages are always a permutation of 0..3.
- IDLE: on Req && Ready, latch Write, Address and BlockIn, then go to LOOKUP. Req while Ready = 0 is ignored and not queued.
- LOOKUP (1 cycle):
  - Hit = some line has valid && tag == Address; the lowest index wins.
  - Miss victim = lowest-index invalid line; otherwise the line with lru == 3.
  - Hit -> UPDATE.
  - Miss with dirty victim -> WB.
  - Clean-victim read miss -> FILL.
  - Clean-victim write miss -> UPDATE. Block = word, so write-allocate needs no fetch.
- WB (1 cycle):
  - C_Write_M = 1, C_Addr_M = victim tag, C_Block_M = victim data.
  - Then read -> FILL, write -> UPDATE.
  - C_Write_M is never high outside WB.
- FILL (MEM_LAT+1 cycles):
  - C_Addr_M = latched Address, C_Write_M = 0.
  - M_Block_C is captured in the last FILL cycle, then -> UPDATE.
- UPDATE (1 cycle), applied to the target line (the hit line or the victim):
  - valid = 1, tag = Address.
  - Write: data = BlockIn, dirty = 1.
  - Read miss: data = fill value, dirty = 0.
  - Read hit: data and dirty unchanged.
  - LRU: with X = the target's old age, every line with age < X gets +1 and the target gets 0.
  - Then -> IDLE, with Done = 1, hit = lookup result and BlockOut = the target's new data, all registered.
- Latency, counted in edges from the accepting edge to Done high:
  - Read or write hit: 2.
  - Clean write miss: 2.
  - Dirty write miss: 3.
  - Clean read miss: 3 + MEM_LAT.
  - Dirty read miss: 4 + MEM_LAT.
- Ready rises in the same cycle as Done. A new Req on the next edge is accepted, giving back-to-back operation.

Decomposition:
- Package cache_pkg holds:
  - TAG_W, DATA_W, LINES, LRU_W.
  - The state enum {IDLE, LOOKUP, WB, FILL, UPDATE}.
  - The line struct {valid, dirty, lru, tag, data}.
- Sub-module cache_lookup (combinational): takes the line array and Address; produces hit, hit_idx and victim_idx, plus victim dirty, tag and data.
- The FSM, FILL counter, line registers and LRU update stay in the top.

Test Plan:
1. Reset; RAM[100] = 5; read 100 -> Done 4 edges after accept, BlockOut = 5, hit = 0, C_Write_M never 1; line0 valid, lru = {0,1,2,3}.
2. Read 100 again -> Done after 2 edges, hit = 1, BlockOut = 5, no FILL, C_Write_M = 0.
3. Write 101 = 3 -> Done after 2 edges, hit = 0, line1 dirty; read 101 -> hit = 1, BlockOut = 3; RAM[101] unchanged.
4. Write 100..103 = 1, 2, 3, 4, then read 104 (RAM[104] = 9):
   - Exactly one C_Write_M pulse, with C_Addr_M = 100 and C_Block_M = 1; RAM[100] = 1.
   - BlockOut = 9, Done after 5 edges.
5. With 100..103 resident, access 100, 101, 102, 103, 100, then read 105 -> line holding 101 evicted; read 101 -> hit = 0.
6. Req pulsed during FILL is ignored, giving no second Done. Reset asserted during WB -> next edge C_Write_M = 0, Ready = 1, all valid = 0, no Done.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and sizing for the 4-line fully-associative cache controller.
package cache_pkg;

  localparam int unsigned TAG_W   = 7;
  localparam int unsigned DATA_W  = 5;
  localparam int unsigned LINES   = 4;
  localparam int unsigned LRU_W   = 2;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned MEM_LAT = 1;
  localparam int unsigned CNT_W   = $clog2(MEM_LAT + 2);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    FILL,
    UPDATE
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [LRU_W-1:0]  lru;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

endpackage

// File: rtl/cache_lookup.sv
// Combinational tag match and replacement-victim selection over the line array.
module cache_lookup
  import cache_pkg::*;
(
  input  line_t [LINES-1:0]  lines,
  input  logic [TAG_W-1:0]   address,
  output logic               hit,
  output logic [IDX_W-1:0]   hit_idx,
  output logic [IDX_W-1:0]   victim_idx,
  output logic               victim_dirty,
  output logic [TAG_W-1:0]   victim_tag,
  output logic [DATA_W-1:0]  victim_data
);

  logic             has_invalid;
  logic [IDX_W-1:0] invalid_idx;
  logic [IDX_W-1:0] oldest_idx;

  // Descending scans so the lowest matching index is the one left standing.
  always_comb begin
    hit         = 1'b0;
    hit_idx     = '0;
    has_invalid = 1'b0;
    invalid_idx = '0;
    oldest_idx  = '0;
    for (int i = int'(LINES) - 1; i >= 0; i--) begin
      if (lines[i].valid && (lines[i].tag == address)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!lines[i].valid) begin
        has_invalid = 1'b1;
        invalid_idx = IDX_W'(i);
      end
      if (lines[i].lru == LRU_W'(LINES - 1)) begin
        oldest_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    victim_idx   = has_invalid ? invalid_idx : oldest_idx;
    victim_dirty = lines[victim_idx].dirty;
    victim_tag   = lines[victim_idx].tag;
    victim_data  = lines[victim_idx].data;
  end

endmodule

// File: rtl/cache_access_controller.sv
// Request sequencer for the 4-line cache: lookup, dirty write-back, fill from RAM,
// line/LRU update and a registered completion pulse.
module cache_access_controller
  import cache_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req,
  input  logic              Write,
  input  logic [TAG_W-1:0]  Address,
  input  logic [DATA_W-1:0] BlockIn,
  output logic              Ready,
  output logic              Done,
  output logic [DATA_W-1:0] BlockOut,
  output logic              hit,
  output logic [TAG_W-1:0]  C_Addr_M,
  output logic [DATA_W-1:0] C_Block_M,
  output logic              C_Write_M,
  input  logic [DATA_W-1:0] M_Block_C
);

  state_t             state;
  state_t             state_next;
  line_t [LINES-1:0]  lines;

  logic               req_write;
  logic [TAG_W-1:0]   req_addr;
  logic [DATA_W-1:0]  req_data;
  logic [IDX_W-1:0]   target_idx;
  logic               lookup_hit;
  logic [CNT_W-1:0]   fill_cnt;
  logic [DATA_W-1:0]  fill_data;

  logic               lk_hit;
  logic [IDX_W-1:0]   lk_hit_idx;
  logic [IDX_W-1:0]   lk_victim_idx;
  logic               lk_victim_dirty;
  logic [TAG_W-1:0]   lk_victim_tag;
  logic [DATA_W-1:0]  lk_victim_data;

  logic               accept;
  logic               lookup_en;
  logic               fill_cap;
  logic               line_upd;
  logic               ready_d;
  logic               done_d;
  logic               hit_d;
  logic [DATA_W-1:0]  block_out_d;
  logic [TAG_W-1:0]   addr_m_d;
  logic [DATA_W-1:0]  block_m_d;
  logic               write_m_d;
  logic [LRU_W-1:0]   target_age;
  logic [DATA_W-1:0]  new_data;

  cache_lookup u_lookup (
    .lines        (lines),
    .address      (req_addr),
    .hit          (lk_hit),
    .hit_idx      (lk_hit_idx),
    .victim_idx   (lk_victim_idx),
    .victim_dirty (lk_victim_dirty),
    .victim_tag   (lk_victim_tag),
    .victim_data  (lk_victim_data)
  );

  // Data the target line will hold after UPDATE; read hits keep their contents.
  always_comb begin
    target_age = lines[target_idx].lru;
    if (req_write) begin
      new_data = req_data;
    end else if (lookup_hit) begin
      new_data = lines[target_idx].data;
    end else begin
      new_data = fill_data;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    lookup_en   = 1'b0;
    fill_cap    = 1'b0;
    line_upd    = 1'b0;
    ready_d     = 1'b0;
    done_d      = 1'b0;
    write_m_d   = 1'b0;
    hit_d       = hit;
    block_out_d = BlockOut;
    addr_m_d    = C_Addr_M;
    block_m_d   = C_Block_M;
    case (state)
      IDLE: begin
        if (Req && Ready) begin
          accept     = 1'b1;
          state_next = LOOKUP;
        end else begin
          ready_d = 1'b1;
        end
      end
      LOOKUP: begin
        lookup_en = 1'b1;
        if (lk_hit) begin
          state_next = UPDATE;
        end else if (lk_victim_dirty) begin
          state_next = WB;
          write_m_d  = 1'b1;
          addr_m_d   = lk_victim_tag;
          block_m_d  = lk_victim_data;
        end else if (req_write) begin
          state_next = UPDATE;
        end else begin
          state_next = FILL;
          addr_m_d   = req_addr;
        end
      end
      WB: begin
        if (req_write) begin
          state_next = UPDATE;
        end else begin
          state_next = FILL;
          addr_m_d   = req_addr;
        end
      end
      FILL: begin
        if (fill_cnt == CNT_W'(MEM_LAT)) begin
          fill_cap   = 1'b1;
          state_next = UPDATE;
        end
      end
      UPDATE: begin
        line_upd    = 1'b1;
        state_next  = IDLE;
        ready_d     = 1'b1;
        done_d      = 1'b1;
        hit_d       = lookup_hit;
        block_out_d = new_data;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered outputs, request latch, fill timing and line storage.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Ready      <= 1'b1;
      Done       <= 1'b0;
      hit        <= 1'b0;
      BlockOut   <= '0;
      C_Addr_M   <= '0;
      C_Block_M  <= '0;
      C_Write_M  <= 1'b0;
      req_write  <= 1'b0;
      req_addr   <= '0;
      req_data   <= '0;
      target_idx <= '0;
      lookup_hit <= 1'b0;
      fill_cnt   <= '0;
      fill_data  <= '0;
      for (int i = 0; i < int'(LINES); i++) begin
        lines[i].valid <= 1'b0;
        lines[i].dirty <= 1'b0;
        lines[i].lru   <= LRU_W'(i);
        lines[i].tag   <= '0;
        lines[i].data  <= '0;
      end
    end else begin
      Ready     <= ready_d;
      Done      <= done_d;
      hit       <= hit_d;
      BlockOut  <= block_out_d;
      C_Addr_M  <= addr_m_d;
      C_Block_M <= block_m_d;
      C_Write_M <= write_m_d;
      if (accept) begin
        req_write <= Write;
        req_addr  <= Address;
        req_data  <= BlockIn;
      end
      if (lookup_en) begin
        target_idx <= lk_hit ? lk_hit_idx : lk_victim_idx;
        lookup_hit <= lk_hit;
      end
      fill_cnt <= (state == FILL) ? fill_cnt + 1'b1 : '0;
      if (fill_cap) begin
        fill_data <= M_Block_C;
      end
      // Target becomes most recent; only lines younger than it age by one.
      if (line_upd) begin
        for (int i = 0; i < int'(LINES); i++) begin
          if (IDX_W'(i) == target_idx) begin
            lines[i].valid <= 1'b1;
            lines[i].tag   <= req_addr;
            lines[i].lru   <= '0;
            lines[i].data  <= new_data;
            if (req_write) begin
              lines[i].dirty <= 1'b1;
            end else if (!lookup_hit) begin
              lines[i].dirty <= 1'b0;
            end
          end else if (lines[i].lru < target_age) begin
            lines[i].lru <= lines[i].lru + 1'b1;
          end
        end
      end
    end
  end

endmodule
